// File: rtl/norm_seq_pkg.sv
// Shared types and constants for the normalization frame sequencer.
package norm_seq_pkg;

   localparam int unsigned DENOM_W    = 8;
   // Width of the reciprocal-LUT settle counter; COEF_LAT must be in 1..256
   localparam int unsigned COEF_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_COEF,
      START,
      RUN,
      ERR
   } nseq_state_e;

endpackage

// File: rtl/norm_seq_cfg_shadow.sv
// Host-side shadow of the normalization denominator: holds the last non-zero
// write, flags it as pending until applied, and latches a sticky zero-write error.
module norm_seq_cfg_shadow
   import norm_seq_pkg::*;
#(
   parameter logic [DENOM_W-1:0] DEFAULT_DENOM = 8'd1
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               wr_valid,
   input  logic [DENOM_W-1:0] wr_data,
   input  logic               apply,
   output logic [DENOM_W-1:0] shadow,
   output logic               pending,
   output logic               zero_err
);

   logic [DENOM_W-1:0] shadow_q, shadow_d;
   logic               pending_q, pending_d;
   logic               zero_err_q, zero_err_d;

   always_comb begin
      shadow_d   = shadow_q;
      pending_d  = pending_q;
      zero_err_d = zero_err_q;
      if (apply) begin
         pending_d = 1'b0;
      end
      // A write landing on the apply cycle re-arms pending for the next frame
      if (wr_valid) begin
         if (wr_data != '0) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
         end else begin
            zero_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         shadow_q   <= DEFAULT_DENOM;
         pending_q  <= 1'b0;
         zero_err_q <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         zero_err_q <= zero_err_d;
      end
   end

   assign shadow   = shadow_q;
   assign pending  = pending_q;
   assign zero_err = zero_err_q;

endmodule

// File: rtl/norm_frame_sequencer.sv
// Per-frame controller for norm_reader: applies the shadowed denominator at frame
// boundaries, waits for the reciprocal LUT, pulses ap_start and counts frames.
// Optional RUN watchdog and ERR state enabled by defining NSEQ_TIMEOUT_EN.
module norm_frame_sequencer
   import norm_seq_pkg::*;
#(
   parameter logic [DENOM_W-1:0] DEFAULT_DENOM = 8'd1,
   parameter int unsigned        COEF_LAT      = 2,
   parameter int unsigned        FRAME_CNT_W   = 16
`ifdef NSEQ_TIMEOUT_EN
   ,parameter int unsigned       TIMEOUT_CYCLES = 2**20
`endif
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   enable,
   input  logic                   frame_avail,
   input  logic [DENOM_W-1:0]     cfg_denominator,
   input  logic                   cfg_denominator_valid,
   input  logic                   norm_ap_ready,
   input  logic                   norm_ap_done,
   output logic                   norm_ap_start,
   output logic [DENOM_W-1:0]     norm_denominator,
   output logic                   norm_denominator_tvalid,
   output logic                   busy,
   output logic                   cfg_pending,
   output logic                   cfg_zero_err,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   err_timeout
);

   nseq_state_e            state_q, state_d;
   logic [COEF_CNT_W-1:0]  coef_cnt_q, coef_cnt_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [DENOM_W-1:0]     denom_q, denom_d;
   logic                   loaded_q, loaded_d;
   logic [DENOM_W-1:0]     shadow;
   logic                   apply;

`ifdef NSEQ_TIMEOUT_EN
   localparam int unsigned RUN_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic                 err_q, err_d;
`endif

   norm_seq_cfg_shadow #(
      .DEFAULT_DENOM (DEFAULT_DENOM)
   ) u_cfg_shadow (
      .clk      (clk),
      .srst     (srst),
      .wr_valid (cfg_denominator_valid),
      .wr_data  (cfg_denominator),
      .apply    (apply),
      .shadow   (shadow),
      .pending  (cfg_pending),
      .zero_err (cfg_zero_err)
   );

   assign apply = (state_q == LOAD);

   always_comb begin
      state_d     = state_q;
      coef_cnt_d  = coef_cnt_q;
      frame_cnt_d = frame_cnt_q;
      denom_d     = denom_q;
      loaded_d    = loaded_q;
`ifdef NSEQ_TIMEOUT_EN
      run_cnt_d   = run_cnt_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (enable && frame_avail && norm_ap_ready) begin
               state_d = (cfg_pending || !loaded_q) ? LOAD : START;
            end
         end
         LOAD: begin
            denom_d    = shadow;
            loaded_d   = 1'b1;
            coef_cnt_d = '0;
            state_d    = WAIT_COEF;
         end
         WAIT_COEF: begin
            if (coef_cnt_q == COEF_CNT_W'(COEF_LAT - 1)) begin
               state_d = START;
            end else begin
               coef_cnt_d = coef_cnt_q + 1'b1;
            end
         end
         START: begin
`ifdef NSEQ_TIMEOUT_EN
            run_cnt_d = '0;
`endif
            state_d = RUN;
         end
         RUN: begin
            if (norm_ap_done) begin
               frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
               state_d     = IDLE;
`ifdef NSEQ_TIMEOUT_EN
            end else if (run_cnt_q == RUN_CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               state_d = ERR;
            end else begin
               run_cnt_d = run_cnt_q + 1'b1;
`endif
            end
         end
`ifdef NSEQ_TIMEOUT_EN
         ERR: state_d = ERR;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= IDLE;
         coef_cnt_q  <= '0;
         frame_cnt_q <= '0;
         denom_q     <= DEFAULT_DENOM;
         loaded_q    <= 1'b0;
`ifdef NSEQ_TIMEOUT_EN
         run_cnt_q   <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         coef_cnt_q  <= coef_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         denom_q     <= denom_d;
         loaded_q    <= loaded_d;
`ifdef NSEQ_TIMEOUT_EN
         run_cnt_q   <= run_cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign norm_ap_start           = (state_q == START);
   // tvalid drops only while the LUT input is being replaced
   assign norm_denominator_tvalid = loaded_q && (state_q != LOAD);
   assign busy                    = (state_q != IDLE) && (state_q != ERR);
   assign norm_denominator        = denom_q;
   assign frame_cnt               = frame_cnt_q;
`ifdef NSEQ_TIMEOUT_EN
   assign err_timeout             = err_q;
`else
   assign err_timeout             = 1'b0;
`endif

endmodule

// File: tb/tb_norm_frame_sequencer.sv
// Self-checking bench for norm_frame_sequencer: directed vector table, a timeline
// reference model under random stimulus, and a watchdog sequence when NSEQ_TIMEOUT_EN is set.
module tb_norm_frame_sequencer;

   localparam int COEF_LAT = 2;
   localparam int CNT_MOD  = 4;
   localparam int TMO      = 16;

   logic       clk = 1'b0;
   logic       srst, enable, frame_avail, cfg_denominator_valid;
   logic       norm_ap_ready, norm_ap_done;
   logic [7:0] cfg_denominator;
   logic       norm_ap_start, norm_denominator_tvalid, busy, cfg_pending;
   logic       cfg_zero_err, err_timeout;
   logic [7:0] norm_denominator;
   logic [1:0] frame_cnt;

   always #5 clk = ~clk;

   norm_frame_sequencer #(
      .DEFAULT_DENOM (8'd1),
      .COEF_LAT      (COEF_LAT),
      .FRAME_CNT_W   (2)
`ifdef NSEQ_TIMEOUT_EN
      ,.TIMEOUT_CYCLES (TMO)
`endif
   ) dut (
      .clk                     (clk),
      .srst                    (srst),
      .enable                  (enable),
      .frame_avail             (frame_avail),
      .cfg_denominator         (cfg_denominator),
      .cfg_denominator_valid   (cfg_denominator_valid),
      .norm_ap_ready           (norm_ap_ready),
      .norm_ap_done            (norm_ap_done),
      .norm_ap_start           (norm_ap_start),
      .norm_denominator        (norm_denominator),
      .norm_denominator_tvalid (norm_denominator_tvalid),
      .busy                    (busy),
      .cfg_pending             (cfg_pending),
      .cfg_zero_err            (cfg_zero_err),
      .frame_cnt               (frame_cnt),
      .err_timeout             (err_timeout)
   );

   typedef struct {
      int srst, en, av, rd, wv, wd, dn;
   } vin_t;

   typedef struct {
      int srst, en, av, rd, wv, wd, dn;
      int st, tv, bz, pd, ze, dm, cnt;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: frame timeline expressed as absolute cycle stamps.
   int   now = 0;
   bit   m_active, m_err, m_pend, m_zerr, m_loaded;
   int   load_at, start_at, m_cnt;
   logic [7:0] m_shadow, m_denom;

   function automatic void model_reset();
      m_active = 0; m_err = 0; m_pend = 0; m_zerr = 0; m_loaded = 0;
      m_cnt = 0; m_shadow = 8'd1; m_denom = 8'd1; load_at = -1; start_at = -1;
   endfunction

   function automatic void model_edge(vin_t v);
      bit in_load, in_run, idle;
      if (v.srst != 0) begin
         model_reset();
         now++;
         return;
      end
      in_load = m_active && (now == load_at);
      in_run  = m_active && (now > start_at);
      idle    = !m_active && !m_err;
      if (idle && v.en != 0 && v.av != 0 && v.rd != 0) begin
         m_active = 1;
         if (m_pend || !m_loaded) begin
            load_at  = now + 1;
            start_at = now + 2 + COEF_LAT;
         end else begin
            load_at  = -1;
            start_at = now + 1;
         end
      end
      if (in_load) begin
         m_denom = m_shadow; m_loaded = 1; m_pend = 0;
      end
      if (v.wv != 0) begin
         if (v.wd != 0) begin
            m_shadow = 8'(v.wd); m_pend = 1;
         end else begin
            m_zerr = 1;
         end
      end
      if (in_run) begin
         if (v.dn != 0) begin
            m_active = 0;
            m_cnt = (m_cnt + 1) % CNT_MOD;
         end
`ifdef NSEQ_TIMEOUT_EN
         else if (now - start_at == TMO) begin
            m_active = 0; m_err = 1;
         end
`endif
      end
      now++;
   endfunction

   function automatic logic [15:0] model_pack();
      bit st, tv;
      st = m_active && (now == start_at);
      tv = m_loaded && !(m_active && (now == load_at));
`ifdef NSEQ_TIMEOUT_EN
      return {2'(m_cnt), m_denom, m_err, m_zerr, m_pend, m_active, tv, st};
`else
      return {2'(m_cnt), m_denom, 1'b0, m_zerr, m_pend, m_active, tv, st};
`endif
   endfunction

   function automatic logic [15:0] dut_pack();
      return {frame_cnt, norm_denominator, err_timeout, cfg_zero_err, cfg_pending,
              busy, norm_denominator_tvalid, norm_ap_start};
   endfunction

   task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got cnt/den/err/ze/pd/bz/tv/st=%h expected %h", nm, act, exp);
   endtask

   task automatic tick(vin_t v);
      srst                  = (v.srst != 0);
      enable                = (v.en != 0);
      frame_avail           = (v.av != 0);
      norm_ap_ready         = (v.rd != 0);
      cfg_denominator_valid = (v.wv != 0);
      cfg_denominator       = 8'(v.wd);
      norm_ap_done          = (v.dn != 0);
      @(posedge clk);
      model_edge(v);
      #1;
      check($sformatf("model@%0d", now), dut_pack(), model_pack());
   endtask

   function automatic vin_t mkin(int s, int e, int wv, int wd, int dn);
      vin_t v;
      v.srst = s; v.en = e; v.av = 1; v.rd = 1; v.wv = wv; v.wd = wd; v.dn = dn;
      return v;
   endfunction

   vec_t vecs[31];

   function automatic vec_t row(int s, int e, int wv, int wd, int dn,
                                int st, int tv, int bz, int pd, int ze, int dm, int c);
      vec_t r;
      r.srst = s; r.en = e; r.av = 1; r.rd = 1; r.wv = wv; r.wd = wd; r.dn = dn;
      r.st = st; r.tv = tv; r.bz = bz; r.pd = pd; r.ze = ze; r.dm = dm; r.cnt = c;
      return r;
   endfunction

   initial begin
      vin_t v;
      int   starts, waited, s_idx;
      model_reset();
      //               srst en wv wd dn | st tv bz pd ze dm cnt
      vecs[0]  = row(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
      vecs[1]  = row(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 1, 0);
      vecs[2]  = row(0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 1, 0);
      vecs[3]  = row(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 0);
      vecs[4]  = row(0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 1, 0);
      vecs[5]  = row(0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 1, 0);
      vecs[6]  = row(0, 0, 1, 8, 0,   0, 1, 1, 1, 0, 1, 0);
      vecs[7]  = row(0, 1, 0, 0, 1,   0, 1, 0, 1, 0, 1, 1);
      vecs[8]  = row(0, 1, 0, 0, 0,   0, 0, 1, 1, 0, 1, 1);
      vecs[9]  = row(0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 8, 1);
      vecs[10] = row(0, 1, 0, 0, 0,   0, 1, 1, 0, 0, 8, 1);
      vecs[11] = row(0, 1, 0, 0, 0,   1, 1, 1, 0, 0, 8, 1);
      vecs[12] = row(0, 1, 1, 0, 0,   0, 1, 1, 0, 1, 8, 1);
      vecs[13] = row(0, 1, 0, 0, 1,   0, 1, 0, 0, 1, 8, 2);
      vecs[14] = row(0, 1, 0, 0, 0,   1, 1, 1, 0, 1, 8, 2);
      vecs[15] = row(0, 1, 1, 5, 0,   0, 1, 1, 1, 1, 8, 2);
      vecs[16] = row(0, 1, 0, 0, 1,   0, 1, 0, 1, 1, 8, 3);
      vecs[17] = row(0, 1, 0, 0, 0,   0, 0, 1, 1, 1, 8, 3);
      vecs[18] = row(0, 1, 1, 9, 0,   0, 1, 1, 1, 1, 5, 3);
      vecs[19] = row(0, 1, 0, 0, 0,   0, 1, 1, 1, 1, 5, 3);
      vecs[20] = row(0, 1, 0, 0, 0,   1, 1, 1, 1, 1, 5, 3);
      vecs[21] = row(0, 1, 0, 0, 0,   0, 1, 1, 1, 1, 5, 3);
      vecs[22] = row(0, 1, 0, 0, 1,   0, 1, 0, 1, 1, 5, 0);
      vecs[23] = row(0, 1, 0, 0, 0,   0, 0, 1, 1, 1, 5, 0);
      vecs[24] = row(0, 1, 0, 0, 0,   0, 1, 1, 0, 1, 9, 0);
      vecs[25] = row(0, 1, 0, 0, 0,   0, 1, 1, 0, 1, 9, 0);
      vecs[26] = row(0, 1, 0, 0, 0,   1, 1, 1, 0, 1, 9, 0);
      vecs[27] = row(0, 1, 0, 0, 0,   0, 1, 1, 0, 1, 9, 0);
      vecs[28] = row(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
      vecs[29] = row(0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0);
      vecs[30] = row(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);

      srst = 1'b1; enable = 1'b0; frame_avail = 1'b0; norm_ap_ready = 1'b0;
      cfg_denominator_valid = 1'b0; cfg_denominator = '0; norm_ap_done = 1'b0;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         v.srst = vecs[i].srst; v.en = vecs[i].en; v.av = vecs[i].av; v.rd = vecs[i].rd;
         v.wv = vecs[i].wv; v.wd = vecs[i].wd; v.dn = vecs[i].dn;
         tick(v);
         check($sformatf("vec[%0d]", i), dut_pack(),
               {2'(vecs[i].cnt), 8'(vecs[i].dm), 1'b0, 1'(vecs[i].ze), 1'(vecs[i].pd),
                1'(vecs[i].bz), 1'(vecs[i].tv), 1'(vecs[i].st)});
      end

      for (int c = 0; c < 1500; c++) begin
         v.srst = ($urandom_range(0, 149) == 0) ? 1 : 0;
         v.en   = ($urandom_range(0, 9) != 0) ? 1 : 0;
         v.av   = ($urandom_range(0, 3) != 0) ? 1 : 0;
         v.rd   = ($urandom_range(0, 3) != 0) ? 1 : 0;
         v.wv   = ($urandom_range(0, 7) == 0) ? 1 : 0;
         v.wd   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
         v.dn   = ($urandom_range(0, 5) == 0) ? 1 : 0;
         tick(v);
      end

`ifdef NSEQ_TIMEOUT_EN
      tick(mkin(1, 0, 0, 0, 0));
      starts = 0; waited = 0; s_idx = -1;
      for (int c = 0; c < 60 && !err_timeout; c++) begin
         tick(mkin(0, 1, 0, 0, 0));
         if (norm_ap_start) s_idx = c;
         waited = c;
      end
      check("timeout_flag", {15'd0, err_timeout}, 16'd1);
      check("timeout_run_cycles", 16'(waited - s_idx), 16'(TMO + 1));
      check("err_busy", {15'd0, busy}, 16'd0);
      for (int c = 0; c < 20; c++) begin
         tick(mkin(0, 1, 0, 0, 0));
         if (norm_ap_start) starts++;
      end
      check("err_no_start", 16'(starts), 16'd0);
      tick(mkin(0, 1, 1, 8'h33, 0));
      check("err_cfg_shadowed", {15'd0, cfg_pending}, 16'd1);
      tick(mkin(1, 0, 0, 0, 0));
      check("err_cleared_by_srst", {15'd0, err_timeout}, 16'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
